// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel coordinates, blanking, sync pulses and strobes.
// Each enabled clock advances one pixel; all outputs are registered and aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_w
      $fatal(1, "vga_timing_gen: totals exceed counter width");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_p
      $fatal(1, "vga_timing_gen: porch/sync must be >= 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON  = 1'(HSYNC_POL);
  localparam logic             VS_ON  = 1'(VSYNC_POL);

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             ls;
    logic             fs;
    logic [CNT_W-1:0] px;
    logic [CNT_W-1:0] py;
  } raster_t;

  localparam raster_t RST_VAL = '{
    hs: ~HS_ON, vs: ~VS_ON, de: 1'b0, ls: 1'b0,
    fs: 1'b0, px: '0, py: '0
  };

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [7:0]       f_cnt;
  logic             h_last;
  logic             v_last;
  raster_t          nxt;
  raster_t          cur;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Decode the pre-increment counters into the next output bundle.
  always_comb begin
    nxt    = RST_VAL;
    nxt.px = h_cnt;
    nxt.py = v_cnt;
    nxt.de = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    nxt.hs = (h_cnt >= H_SS && h_cnt < H_SE) ? HS_ON : ~HS_ON;
    nxt.vs = (v_cnt >= V_SS && v_cnt < V_SE) ? VS_ON : ~VS_ON;
    nxt.ls = (h_cnt == '0);
    nxt.fs = (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster counters and completed-frame count, advancing on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      f_cnt <= '0;
    end else if (ena) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        if (v_last) begin
          f_cnt <= f_cnt + 8'd1;
        end
      end
    end
  end

  // Output register; pulses are held along with everything else when ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= RST_VAL;
    end else if (ena) begin
      cur <= nxt;
    end
  end

  assign hsync       = cur.hs;
  assign vsync       = cur.vs;
  assign display_on  = cur.de;
  assign line_start  = cur.ls;
  assign frame_start = cur.fs;
  assign x           = cur.px;
  assign y           = cur.py;
  assign frame_cnt   = f_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny
// active-high-sync instance used for vertical timing and frame wrap.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_d = 1'b0, ena_d = 1'b0;
  logic rst_s = 1'b0, ena_s = 1'b0;

  logic       hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [7:0] fc_d;
  logic       hs_s, vs_s, de_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;
  logic [7:0] fc_s;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_d), .ena(ena_d),
    .hsync(hs_d), .vsync(vs_d), .display_on(de_d),
    .x(x_d), .y(y_d), .line_start(ls_d),
    .frame_start(fs_d), .frame_cnt(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(10)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .ena(ena_s),
    .hsync(hs_s), .vsync(vs_s), .display_on(de_s),
    .x(x_s), .y(y_s), .line_start(ls_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  int tests = 0;
  int fails = 0;
  int nprint = 0;

  // Enabled edges since the last reset, per instance.
  int n_d = 0;
  int n_s = 0;
  always @(posedge clk or negedge rst_d)
    if (!rst_d) n_d <= 0;
    else if (ena_d) n_d <= n_d + 1;
  always @(posedge clk or negedge rst_s)
    if (!rst_s) n_s <= 0;
    else if (ena_s) n_s <= n_s + 1;

  // Expected outputs after n enabled edges: the outputs show raster
  // position n-1, and a frame has completed every ht*vt edges.
  function automatic obs_t model(int n,
      int ha, int hf, int hw, int hb,
      int va, int vf, int vw, int vb,
      bit hp, bit vp);
    obs_t o;
    int ht, vt, p, h, v;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (n == 0) return o;
    p = n - 1;
    h = p % ht;
    v = (p / ht) % vt;
    o.x  = 10'(h);
    o.y  = 10'(v);
    o.de = (h < ha) && (v < va);
    o.hs = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
    o.vs = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.fc = 8'((n / (ht * vt)) % 256);
    return o;
  endfunction

  task automatic cmp_obs(string name, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
          name, $time, act.x, act.y, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
          exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Continuous check of both instances against the model.
  always @(negedge clk) begin
    cmp_obs("model_dflt",
      '{x_d, y_d, hs_d, vs_d, de_d, ls_d, fs_d, fc_d},
      model(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    cmp_obs("model_small",
      '{x_s, y_s, hs_s, vs_s, de_s, ls_s, fs_s, fc_s},
      model(n_s, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  int last_ls, per_ls, hs_low, hs_first, hs_last, k;
  int vs_hi, vs_bad, hs_hi, hs_bad, fs_prev, fs_per;

  initial begin
    #80;
    chk("rst_hsync", hs_d, 1);
    chk("rst_vsync", vs_d, 1);
    chk("rst_de", de_d, 0);
    chk("rst_x", x_d, 0);
    chk("rst_y", y_d, 0);
    chk("rst_fc", fc_d, 0);
    chk("rst_small_hsync", hs_s, 0);
    chk("rst_small_vsync", vs_s, 0);

    @(posedge clk);
    #5;
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) edge1();
    chk("hold_x", x_d, 0);
    chk("hold_ls", ls_d, 0);
    chk("hold_hsync", hs_d, 1);

    #4;
    ena_d = 1'b1;
    edge1();
    chk("first_x", x_d, 0);
    chk("first_y", y_d, 0);
    chk("first_fs", fs_d, 1);
    chk("first_ls", ls_d, 1);
    chk("first_de", de_d, 1);
    edge1();
    chk("second_x", x_d, 1);
    chk("second_fs", fs_d, 0);
    chk("second_ls", ls_d, 0);

    last_ls = 1;
    per_ls = -1;
    hs_low = 0;
    hs_first = -1;
    hs_last = -1;
    for (int e = 3; e <= 1700; e++) begin
      edge1();
      if (ls_d) begin
        if (per_ls < 0) per_ls = e - last_ls;
        last_ls = e;
      end
      if (y_d == 0 && !hs_d) begin
        hs_low++;
        if (hs_first < 0) hs_first = x_d;
        hs_last = x_d;
      end
      if (y_d == 0 && x_d == 639) chk("de_x639", de_d, 1);
      if (y_d == 0 && x_d == 640) chk("de_x640", de_d, 0);
    end
    chk("ls_period", per_ls, 800);
    chk("hs_low_cnt", hs_low, 96);
    chk("hs_first_x", hs_first, 656);
    chk("hs_last_x", hs_last, 751);

    for (int i = 0; i < 2000; i++) begin
      #4;
      ena_d = 1'($urandom % 2);
      edge1();
    end
    #4;
    ena_d = 1'b1;
    k = 0;
    edge1();
    while (x_d != 300 && k < 1000) begin
      edge1();
      k++;
    end
    chk("reach_x300", int'(x_d), 300);
    #10;
    rst_d = 1'b0;
    #1;
    chk("arst_x", x_d, 0);
    chk("arst_y", y_d, 0);
    chk("arst_hsync", hs_d, 1);
    chk("arst_vsync", vs_d, 1);
    chk("arst_de", de_d, 0);
    chk("arst_fc", fc_d, 0);
    @(posedge clk);
    #5;
    rst_d = 1'b1;
    edge1();
    chk("restart_x", x_d, 0);
    chk("restart_y", y_d, 0);
    chk("restart_fs", fs_d, 1);

    #4;
    ena_d = 1'b0;
    ena_s = 1'b1;
    vs_hi = 0;
    vs_bad = 0;
    hs_hi = 0;
    hs_bad = 0;
    fs_prev = -1;
    fs_per = -1;
    for (int e = 1; e <= 257 * 48; e++) begin
      edge1();
      if (vs_s) begin
        if (e <= 48) vs_hi++;
        if (y_s != 4) vs_bad++;
      end
      if (hs_s) begin
        if (e <= 48) hs_hi++;
        if (x_s != 5 && x_s != 6) hs_bad++;
      end
      if (fs_s) begin
        if (fs_prev > 0 && fs_per < 0) fs_per = e - fs_prev;
        fs_prev = e;
      end
      if (e == 96) chk("fc_after2", fc_s, 2);
      if (e == 255 * 48) chk("fc_255", fc_s, 255);
      if (e == 256 * 48) chk("fc_wrap", fc_s, 0);
    end
    chk("small_vs_hi", vs_hi, 8);
    chk("small_vs_bad", vs_bad, 0);
    chk("small_hs_hi", hs_hi, 12);
    chk("small_hs_bad", hs_bad, 0);
    chk("small_fs_period", fs_per, 48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
